// File: rtl/aes_dec_iter_ctrl_if.sv
// Host-side bus of the iterative AES-128 decrypt sequencer.
// Carries the key-load port and the ciphertext-in / plaintext-out valid-ready streams.
interface aes_dec_iter_ctrl_if;
  logic         key_load;
  logic [127:0] key;
  logic         key_busy;
  logic         key_ok;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipher_text;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plain_text;

  modport master (
    output key_load, key, in_valid, cipher_text, out_ready,
    input  key_busy, key_ok, in_ready, out_valid, plain_text
  );

  modport slave (
    input  key_load, key, in_valid, cipher_text, out_ready,
    output key_busy, key_ok, in_ready, out_valid, plain_text
  );
endinterface

// File: rtl/aes_dec_iter_ctrl.sv
// Sequencer for an iterative AES-128 decryptor: expands and stores the 11 round keys once,
// then drives one shared inverse-round datapath for 10 cycles per block.
module aes_dec_iter_ctrl #(
  parameter int NR     = 10,
  parameter int RIDX_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_dec_iter_ctrl_if.slave  host,
  output logic [127:0]        ke_key_o,
  output logic [RIDX_W-1:0]   ke_ridx_o,
  input  logic [127:0]        ke_key_i,
  output logic [127:0]        dp_state_o,
  output logic [127:0]        dp_key_o,
  output logic                dp_first_o,
  input  logic [127:0]        dp_state_i
);

  typedef enum logic [1:0] {IDLE, KEYEXP, RUN, DONE} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q;
  logic [127:0] rk_q [0:NR];
  logic [127:0] st_q;
  logic [127:0] plain_q;
  logic         out_valid_q;
  logic         key_ok_q;
  logic         key_busy_q;
  logic         busy_state;
  logic         cnt_abort;
  logic         cnt_last;
  logic         in_ready;
  logic         accept;

  // KEYEXP and RUN only ever see cnt in 1..NR; anything else is corrupted state.
  assign busy_state = (state_q == KEYEXP) || (state_q == RUN);
  assign cnt_abort  = (cnt_q > LAST) || (busy_state && (cnt_q == 4'd0));
  assign cnt_last   = (cnt_q == LAST);

  // A pending key load wins over new data in the same cycle.
  assign in_ready = (state_q == IDLE) && key_ok_q && !host.key_load;
  assign accept   = host.in_valid && in_ready;

  assign host.in_ready   = in_ready;
  assign host.key_ok     = key_ok_q;
  assign host.key_busy   = key_busy_q;
  assign host.out_valid  = out_valid_q;
  assign host.plain_text = plain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a missing assignment on some path would infer a latch.
    state_d    = state_q;
    ke_key_o   = '0;
    ke_ridx_o  = '0;
    dp_state_o = '0;
    dp_key_o   = '0;
    dp_first_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (host.key_load) state_d = KEYEXP;
        else if (accept)   state_d = RUN;
      end
      KEYEXP: begin
        if (!cnt_abort) begin
          ke_key_o  = rk_q[cnt_q - 4'd1];
          ke_ridx_o = RIDX_W'(cnt_q);
        end
        if (cnt_last) state_d = IDLE;
      end
      RUN: begin
        if (!cnt_abort) begin
          dp_state_o = st_q;
          dp_key_o   = rk_q[4'd11 - cnt_q];
          dp_first_o = (cnt_q == 4'd1);
        end
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        if (host.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cnt_abort) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      st_q        <= '0;
      plain_q     <= '0;
      out_valid_q <= 1'b0;
      key_ok_q    <= 1'b0;
      key_busy_q  <= 1'b0;
      // NOTE: the round-key file is reset as registers so a reset always invalidates stored keys.
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host.key_load) begin
            rk_q[0]    <= host.key;
            cnt_q      <= 4'd1;
            key_ok_q   <= 1'b0;
            key_busy_q <= 1'b1;
          end else if (accept) begin
            st_q  <= host.cipher_text;
            cnt_q <= 4'd1;
          end
        end
        KEYEXP: begin
          if (!cnt_abort) begin
            rk_q[cnt_q] <= ke_key_i;
            if (cnt_last) begin
              key_ok_q   <= 1'b1;
              key_busy_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        RUN: begin
          if (!cnt_abort) begin
            if (cnt_last) begin
              plain_q     <= dp_state_i ^ rk_q[0];
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
            end else begin
              st_q  <= dp_state_i;
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        DONE: begin
          if (host.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase

      if (cnt_abort) begin
        cnt_q      <= '0;
        key_busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Bench for aes_dec_iter_ctrl: behavioural expandkey and inverse-round models close the loop,
// a scoreboard queue holds expected plaintexts and a monitor compares on each output handshake.
module tb_aes_dec_iter_ctrl;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT3 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT4 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT4 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] ke_key_o, ke_key_i, dp_state_o, dp_key_o, dp_state_i;
  logic [7:0]   ke_ridx_o;
  logic         dp_first_o;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [127:0] plain;
    int           acc;
  } exp_t;

  exp_t sb_q[$];

  aes_dec_iter_ctrl_if bus ();

  aes_dec_iter_ctrl #(.NR(10), .RIDX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (bus),
    .ke_key_o   (ke_key_o),
    .ke_ridx_o  (ke_ridx_o),
    .ke_key_i   (ke_key_i),
    .dp_state_o (dp_state_o),
    .dp_key_o   (dp_key_o),
    .dp_first_o (dp_first_o),
    .dp_state_i (dp_state_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // AES reference arithmetic for the external expandkey and inverse-round stages.
  logic [7:0] sbox     [256];
  logic [7:0] inv_sbox [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  initial begin
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[a]     = s;
      inv_sbox[s] = 8'(a);
    end
  end

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] ridx);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 1; i < int'(ridx); i++) rc = xtime(rc);
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]};
    t[31:24] = t[31:24] ^ rc;
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // First round: AddRoundKey then InvShiftRows/InvSubBytes; later rounds add InvMixColumns after the key.
  function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] k,
                                             input logic first);
    logic [127:0] x, y;
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    x = st ^ k;
    for (int i = 0; i < 16; i++) b[i] = x[127-8*i -: 8];
    if (!first) begin
      for (int c = 0; c < 4; c++) begin
        m[4*c+0] = gmul(b[4*c], 8'h0e) ^ gmul(b[4*c+1], 8'h0b) ^ gmul(b[4*c+2], 8'h0d) ^ gmul(b[4*c+3], 8'h09);
        m[4*c+1] = gmul(b[4*c], 8'h09) ^ gmul(b[4*c+1], 8'h0e) ^ gmul(b[4*c+2], 8'h0b) ^ gmul(b[4*c+3], 8'h0d);
        m[4*c+2] = gmul(b[4*c], 8'h0d) ^ gmul(b[4*c+1], 8'h09) ^ gmul(b[4*c+2], 8'h0e) ^ gmul(b[4*c+3], 8'h0b);
        m[4*c+3] = gmul(b[4*c], 8'h0b) ^ gmul(b[4*c+1], 8'h0d) ^ gmul(b[4*c+2], 8'h09) ^ gmul(b[4*c+3], 8'h0e);
      end
      b = m;
    end
    y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127-8*(4*c+r) -: 8] = inv_sbox[b[4*((c - r + 4) % 4) + r]];
    return y;
  endfunction

  assign ke_key_i   = expand_key(ke_key_o, ke_ridx_o);
  assign dp_state_i = inv_round(dp_state_o, dp_key_o, dp_first_o);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, i.e. the values the next rising edge will see.
  logic ov_prev = 1'b0;
  exp_t mon_e;

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.out_valid && !ov_prev) begin
        if (sb_q.size() == 0) check("spurious_out_valid", 128'(bus.out_valid), 128'd0);
        else                  check("latency", 128'(cyc - sb_q[0].acc), 128'd10);
      end
      if (bus.out_valid && bus.out_ready && sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("plain_text", bus.plain_text, mon_e.plain);
      end
      ov_prev = bus.out_valid;
    end
  end

  task automatic send_block(input logic [127:0] ct, input logic [127:0] pt, output int acc);
    exp_t e;
    bit   done;
    done = 1'b0;
    acc  = -1;
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.cipher_text = ct;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (bus.in_ready) begin
        done    = 1'b1;
        acc     = cyc + 1;
        e.plain = pt;
        e.acc   = acc;
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) check("in_ready_timeout", 128'(bus.in_ready), 128'd1);
  endtask

  task automatic load_key(input logic [127:0] k);
    int n;
    n = 0;
    @(negedge clk);
    bus.key_load = 1'b1;
    bus.key      = k;
    @(negedge clk);
    bus.key_load = 1'b0;
    while (!bus.key_ok && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("key_ok_after_load", 128'(bus.key_ok), 128'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 128'(sb_q.size()), 128'd0);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_valid"},  128'(bus.out_valid),  '0);
    check({tag, "_plain_text"}, bus.plain_text,       '0);
    check({tag, "_key_ok"},     128'(bus.key_ok),     '0);
    check({tag, "_key_busy"},   128'(bus.key_busy),   '0);
    check({tag, "_in_ready"},   128'(bus.in_ready),   '0);
    check({tag, "_ke_key"},     ke_key_o,             '0);
    check({tag, "_ke_ridx"},    128'(ke_ridx_o),      '0);
    check({tag, "_dp_state"},   dp_state_o,           '0);
    check({tag, "_dp_key"},     dp_key_o,             '0);
    check({tag, "_dp_first"},   128'(dp_first_o),     '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, a1, a2, a3;
    bus.key_load    = 1'b0;
    bus.key         = '0;
    bus.in_valid    = 1'b0;
    bus.cipher_text = '0;
    bus.out_ready   = 1'b1;
    rst_n           = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // No key loaded: data must never be accepted.
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.cipher_text = CT1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      check("nokey_in_ready", 128'(bus.in_ready), 128'd0);
      check("nokey_out_valid", 128'(bus.out_valid), 128'd0);
    end
    bus.in_valid = 1'b0;

    // FIPS-197 C.1.
    load_key(K1);
    send_block(CT1, PT1, a1);
    drain();

    // FIPS-197 App.B, then two more blocks on the stored key, back to back.
    load_key(K2);
    send_block(CT2, PT2, a1);
    send_block(CT3, PT3, a2);
    send_block(CT4, PT4, a3);
    check("throughput_1", 128'(a2 - a1), 128'd12);
    check("throughput_2", 128'(a3 - a2), 128'd12);
    drain();

    // Backpressure: output held, new data ignored.
    bus.out_ready = 1'b0;
    send_block(CT2, PT2, a1);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    bus.in_valid    = 1'b1;
    bus.cipher_text = CT1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", 128'(bus.out_valid), 128'd1);
      check("bp_plain_text", bus.plain_text, PT2);
      check("bp_in_ready", 128'(bus.in_ready), 128'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Key load and data offered together: the load wins.
    @(negedge clk);
    bus.key_load    = 1'b1;
    bus.key         = K1;
    bus.in_valid    = 1'b1;
    bus.cipher_text = CT1;
    #1;
    check("prio_in_ready", 128'(bus.in_ready), 128'd0);
    @(negedge clk);
    bus.key_load = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("prio_key_ok_low", 128'(bus.key_ok), 128'd0);
      check("prio_key_busy", 128'(bus.key_busy), 128'd1);
      check("prio_ke_ridx", 128'(ke_ridx_o), 128'(i + 1));
      @(negedge clk);
    end
    check("prio_key_ok_high", 128'(bus.key_ok), 128'd1);
    check("prio_key_busy_done", 128'(bus.key_busy), 128'd0);
    send_block(CT1, PT1, a1);
    drain();

    // Reset in the middle of a block.
    send_block(CT1, PT1, a1);
    repeat (4) @(negedge clk);
    check("abort_dp_key_live", 128'(dp_key_o != '0), 128'd1);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check_outputs_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid    = 1'b1;
    bus.cipher_text = CT1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("abort_in_ready", 128'(bus.in_ready), 128'd0);
      check("abort_out_valid", 128'(bus.out_valid), 128'd0);
    end
    bus.in_valid = 1'b0;
    load_key(K1);
    #1;
    check("reload_in_ready", 128'(bus.in_ready), 128'd1);
    send_block(CT1, PT1, a1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
